// File: rtl/arb_req_queues_pkg.sv
// Shared definitions for the arbiter request-queue front end.
//   N_REQ  : requester count, equal to the round-robin arbiter width
//   SRC_W  : width of a requester index
//   DATA_W : default payload width per requester
//   DEPTH  : default entries per requester queue
//   onehot_to_idx() : one-hot to binary index; the lowest set bit wins, so a
//                     malformed vector still yields a single deterministic index.
package arb_req_queues_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;

  function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SRC_W-1:0] idx;
    idx = '0;
    // Scan from the top so the lowest set bit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_queues_fifo.sv
// Synchronous FIFO with an occupancy count, one instance per requester.
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high reset (empties the FIFO)
//   push_i  : write data_i at the tail when not full
//   data_i  : write data
//   pop_i   : advance the head when not empty
//   head_o  : current head entry (undefined while empty)
//   count_o : number of stored entries, 0..Depth
//   ready_o : FIFO not full (no look-ahead at a same-cycle pop)
module arb_req_queues_fifo #(
  parameter int unsigned DataW = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DataW-1:0]           data_i,
  input  logic                       pop_i,
  output logic [DataW-1:0]           head_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       ready_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign ready_o = (count_q != CntW'(Depth));
  assign push_en = push_i && ready_o;
  assign pop_en  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    // Power-of-two depth: pointers wrap by plain overflow.
    rd_ptr_d = pop_en  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/arb_req_queues.sv
// Upstream feeder for the 8-way round-robin arbiter: one FIFO per requester,
// requests driven from queue occupancy, granted heads popped into a single
// registered output stream.
//   clk_i           : rising-edge clock
//   rst_i           : asynchronous active-high reset
//   in_valid_i      : per-requester push request
//   in_data_i       : payloads, slice i = [i*DataW +: DataW]
//   in_ready_o      : per-requester queue not full
//   req_o           : request vector to the arbiter
//   gnt_i           : registered grant from the arbiter, one-hot or zero
//   out_valid_o     : one-cycle pulse per popped word
//   out_data_o      : popped word (holds when nothing popped)
//   out_src_o       : requester index of out_data_o (holds when nothing popped)
//   err_gnt_empty_o : sticky, a grant arrived for an empty queue
module arb_req_queues
  import arb_req_queues_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned Depth = DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       in_valid_i,
  input  logic [N_REQ*DataW-1:0] in_data_i,
  output logic [N_REQ-1:0]       in_ready_o,
  output logic [N_REQ-1:0]       req_o,
  input  logic [N_REQ-1:0]       gnt_i,
  output logic                   out_valid_o,
  output logic [DataW-1:0]       out_data_o,
  output logic [SRC_W-1:0]       out_src_o,
  output logic                   err_gnt_empty_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [N_REQ-1:0][CntW-1:0]  count;
  logic [N_REQ-1:0][DataW-1:0] head;
  logic [N_REQ-1:0]            nonempty;
  logic [N_REQ-1:0]            pop_cand;
  logic [N_REQ-1:0]            pop_sel;
  logic [SRC_W-1:0]            pop_idx;

  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic             err_q, err_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_queue
    arb_req_queues_fifo #(
      .DataW (DataW),
      .Depth (Depth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (in_valid_i[i]),
      .data_i  (in_data_i[i*DataW +: DataW]),
      .pop_i   (pop_sel[i]),
      .head_o  (head[i]),
      .count_o (count[i]),
      .ready_o (in_ready_o[i])
    );
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nonempty[i] = (count[i] != '0);
      // The entry popped this cycle is already claimed; without this a queue
      // holding one word would draw a second grant a cycle later.
      req_o[i]    = (count[i] > CntW'(gnt_i[i]));
    end
  end

  // Isolate the lowest granted nonempty queue so a malformed grant pops once.
  assign pop_cand = gnt_i & nonempty;
  assign pop_sel  = pop_cand & (~pop_cand + N_REQ'(1));
  assign pop_idx  = onehot_to_idx(pop_sel);

  always_comb begin
    out_valid_d = |pop_sel;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (|pop_sel) begin
      out_data_d = head[pop_idx];
      out_src_d  = pop_idx;
    end
    err_d = err_q | (|(gnt_i & ~nonempty));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign out_src_o       = out_src_q;
  assign err_gnt_empty_o = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert ($onehot0(gnt_i));
  end

endmodule

// File: tb/tb_arb_req_queues.sv
module tb_arb_req_queues;

  localparam int NR = 8;
  localparam int DW = 16;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    in_valid;
  logic [NR*DW-1:0] in_data;
  logic [NR-1:0]    in_ready;
  logic [NR-1:0]    req;
  logic [NR-1:0]    gnt;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [2:0]       out_src;
  logic             err_gnt_empty;

  arb_req_queues dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .in_ready_o      (in_ready),
    .req_o           (req),
    .gnt_i           (gnt),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .out_src_o       (out_src),
    .err_gnt_empty_o (err_gnt_empty)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one queue of words per requester plus expected output regs.
  logic [DW-1:0] mq [NR][$];
  logic          exp_valid, exp_err;
  logic [DW-1:0] exp_data;
  logic [2:0]    exp_src;
  // Round-robin arbiter standing in for the real one (registered grant).
  logic [NR-1:0] arb_gnt;
  int            rr_ptr;
  int            cyc;
  int            src_log[$];
  int            cyc_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mq[i].delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = '0;
    exp_src   = '0;
    arb_gnt   = '0;
    rr_ptr    = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = '0;
    gnt      = '0;
    #1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'hFF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_err", 32'(err_gnt_empty), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational outputs, then advance the model across the coming edge.
  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                      input bit use_arb, input logic [NR-1:0] gf);
    logic [NR-1:0] g, mreq, mrdy, empt;
    int            sz[NR];
    int            pidx;
    bit            found;
    @(negedge clk);
    cyc++;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("out_src", 32'(out_src), 32'(exp_src));
    chk("err_gnt_empty", 32'(err_gnt_empty), 32'(exp_err));
    if (out_valid === 1'b1) begin
      src_log.push_back(int'(out_src));
      cyc_log.push_back(cyc);
    end
    g        = use_arb ? arb_gnt : gf;
    gnt      = g;
    in_valid = v;
    in_data  = d;
    #1;
    for (int i = 0; i < NR; i++) begin
      sz[i]   = mq[i].size();
      mrdy[i] = (sz[i] < DP);
      mreq[i] = (sz[i] > int'(g[i]));
      empt[i] = (sz[i] == 0);
    end
    chk("req", 32'(req), 32'(mreq));
    chk("in_ready", 32'(in_ready), 32'(mrdy));
    pidx = -1;
    for (int i = NR - 1; i >= 0; i--) if (g[i] && !empt[i]) pidx = i;
    if (pidx >= 0) begin
      exp_data  = mq[pidx].pop_front();
      exp_src   = 3'(pidx);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if ((g & empt) != '0) exp_err = 1'b1;
    for (int i = 0; i < NR; i++) if (v[i] && mrdy[i]) mq[i].push_back(d[i*DW +: DW]);
    arb_gnt = '0;
    found   = 1'b0;
    if (use_arb) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (rr_ptr + k) % NR;
        if (!found && mreq[j]) begin
          arb_gnt[j] = 1'b1;
          rr_ptr     = (j + 1) % NR;
          found      = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [NR*DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [NR*DW-1:0] d;
    cyc      = 0;
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    gnt      = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_req", 32'(req), 32'h0);
    chk("init_in_ready", 32'(in_ready), 32'hFF);
    chk("init_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // Single word through queue 3, latency and no second grant.
    src_log.delete();
    d = '0;
    d[3*DW +: DW] = 16'hA5A5;
    step(8'h08, d, 1'b1, '0);
    repeat (3) step('0, '0, 1'b1, '0);
    chk("single_data", 32'(out_data), 32'hA5A5);
    chk("single_src", 32'(out_src), 32'h3);
    repeat (3) step('0, '0, 1'b1, '0);
    chk("single_no_regrant", 32'(src_log.size()), 32'h1);

    // Fairness: two words in every queue, arbiter attached from a fresh pointer.
    reset_dut();
    src_log.delete();
    cyc_log.delete();
    repeat (2) step(8'hFF, rnd_data(), 1'b0, '0);
    repeat (20) step('0, '0, 1'b1, '0);
    chk("fair_count", 32'(src_log.size()), 32'd16);
    if (src_log.size() == 16) begin
      for (int k = 0; k < 16; k++) chk("fair_src", 32'(src_log[k]), 32'(k % NR));
      chk("fair_b2b", 32'(cyc_log[15] - cyc_log[0]), 32'd15);
    end

    // Full and pointer wrap on queue 6.
    repeat (5) step(8'h40, rnd_data(), 1'b0, '0);
    chk("full_ready6", 32'(in_ready[6]), 32'h0);
    repeat (6) step(8'h40, rnd_data(), 1'b0, 8'h40);
    repeat (8) step('0, '0, 1'b1, '0);

    // Queue 1: pop while full, then push+pop at count 2.
    repeat (4) step(8'h02, rnd_data(), 1'b0, '0);
    step(8'h02, rnd_data(), 1'b0, 8'h02);
    step('0, '0, 1'b0, '0);
    chk("pop_full_ready1", 32'(in_ready[1]), 32'h1);
    step('0, '0, 1'b0, 8'h02);
    step(8'h02, rnd_data(), 1'b0, 8'h02);
    repeat (6) step('0, '0, 1'b1, '0);

    // Grant to an empty queue 4.
    step('0, '0, 1'b0, 8'h10);
    step('0, '0, 1'b0, '0);
    chk("bad_gnt_err", 32'(err_gnt_empty), 32'h1);
    chk("bad_gnt_valid", 32'(out_valid), 32'h0);

    // Random traffic with the arbiter attached; error stays sticky.
    for (int n = 0; n < 300; n++) step(8'($urandom() & $urandom()), rnd_data(), 1'b1, '0);
    chk("err_sticky", 32'(err_gnt_empty), 32'h1);

    // Reset mid-stream with queues 2 and 5 partly full.
    repeat (2) step(8'h24, rnd_data(), 1'b0, '0);
    step(8'h24, rnd_data(), 1'b1, '0);
    reset_dut();

    for (int n = 0; n < 300; n++) step(8'($urandom()), rnd_data(), 1'b1, '0);
    repeat (12) step('0, '0, 1'b1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
